alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
Parametrised, sequenced successor to the combinational ALU control decoder.
- Accepts one decoded instruction (funct7+funct3, ALUOp) per valid/ready handshake and latches the ALU control code.
- Issues that code to the ALU for a per-op number of beats. Multi-cycle CNN ops (MaxPool, FC, Conv2d, BatchNorm) drive the datapath over several cycles.
- Sits between the ID/EX control path and the ALU/CNN datapath, and stalls the pipeline via ready_o while busy.

Parameters:
CTRL_W, 4, width of ALU control code.
ITER_W, 8, width of beat counter.
POOL_BEATS, 4, beats for MaxPool (2x2 window); legal range 1..2^ITER_W-1.
FC_BEATS, 16, beats for FC; legal range 1..2^ITER_W-1.
CONV_BEATS, 9, beats for Conv2d (3x3 kernel); legal range 1..2^ITER_W-1.
BN_BEATS, 2, beats for BatchNorm; legal range 1..2^ITER_W-1.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_n_i  in  1  synchronous, active-low reset.
valid_i  in  1  instruction present.
funct_i  in  10  {funct7[6:0], funct3[2:0]}.
ALUOp_i  in  2  op class from main control.
ready_o  out  1  block can accept an instruction.
alu_ready_i  in  1  ALU consumes the current beat.
flush_i  in  1  abort current op (branch/flush).
ALUCtrl_o  out  CTRL_W  ALU control code.
alu_valid_o  out  1  beat valid.
iter_o  out  ITER_W  current beat index.
first_o  out  1  beat index == 0 while alu_valid_o.
last_o  out  1  beat index == N-1 while alu_valid_o.
busy_o  out  1  state != IDLE.
done_o  out  1  one-cycle pulse after the last beat.

Behaviour:
Reset:
- While rst_n_i is low at a clock edge: state=IDLE, ALUCtrl_o=0001, alu_valid_o=0, iter_o=0, done_o=0, busy_o=0.
- ready_o=0 while rst_n_i is low; otherwise ready_o = (state==IDLE).
- Reset mid-operation discards the op with no done_o.

Decode:
- ALUOp 11 → 0001 add.
- ALUOp 01 → 0010 sub.
- ALUOp 00 → 0001 add.
- ALUOp 10 decodes funct_i:
  - 0000000000 → 0001 add.
  - 0100000000 → 0010 sub.
  - 0000001000 → 0110 mul.
  - 0000000110 → 0100 or.
  - 0000000111 → 0011 and.
  - 1000000111 → 0111 ReLU.
  - 1100000111 → 1000 MaxPool, N=POOL_BEATS.
  - 1110000111 → 1001 FC, N=FC_BEATS.
  - 1111000111 → 1010 Conv2d, N=CONV_BEATS.
  - 1010000111 → 1011 BatchNorm, N=BN_BEATS.
  - anything else → 0001 (legacy default).
- N=1 for every op not listed with a beat count.

State machine (IDLE, RUN, DONE):
- IDLE: on valid_i && ready_o, latch code and N; iter=0; go to RUN.
- RUN: alu_valid_o=1, ALUCtrl_o holds the latched code.
  - alu_ready_i=1: the beat is consumed; iter increments.
  - On the beat where iter==N-1 and alu_ready_i=1, go to DONE.
  - alu_ready_i=0: all outputs hold.
- DONE: done_o=1 and alu_valid_o=0 for one cycle, then IDLE.
- ALUCtrl_o holds its last value in IDLE and DONE.
- Latency, single-beat op with alu_ready_i=1:
  - accept at edge T;
  - beat during cycle T+1;
  - done_o during T+2;
  - ready_o during T+3.
- N=1: first_o and last_o are both high on the single beat.
- iter_o never wraps; it is bounded by N-1.

Flush:
- flush_i in RUN or DONE → IDLE next edge, alu_valid_o=0, done_o=0.
- flush_i in IDLE blocks acceptance that cycle; flush has priority over accept.
- flush_i together with a final beat: flush wins, no done_o.
- valid_i while busy is ignored; upstream holds the instruction until ready_o.

Optional Feature:
Macro ALU_CTRL_ILLEGAL_EN.
- Defined: adds output illegal_o (1 bit, reset 0).
  - An ALUOp=10 instruction whose funct_i is not in the decode table is accepted but not issued.
  - Path: IDLE → DONE directly; alu_valid_o stays 0.
  - illegal_o and done_o pulse together for one cycle.
- Undefined: no illegal_o port; unknown funct issues one add beat (0001).

Test Plan:
- Reset: rst_n_i=0 for 2 cycles with valid_i=1 → ALUCtrl_o=0001, alu_valid_o=0, ready_o=0; after release ready_o=1.
- ALUOp=10, funct=0100000000, alu_ready_i=1 → one beat of 0010 with first_o=last_o=1; done_o pulses 2 cycles after accept.
- Conv2d (1111000111), CONV_BEATS=9, alu_ready_i deasserted on beats 3 and 6 → 9 beats of 1010 with iter_o 0..8, outputs held during stalls, done_o once, 11 RUN cycles.
- FC op, flush_i asserted at iter_o=5 → alu_valid_o=0 next cycle, no done_o, ready_o=1; a following add is accepted normally.
- ALUOp=01 and ALUOp=11 (funct ignored) → single beats of 0010 and 0001 respectively.
- funct=0000000001, ALUOp=10 → without the macro: one 0001 beat. With ALU_CTRL_ILLEGAL_EN: no beat, illegal_o=done_o=1 for one cycle.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Sequenced ALU control: decodes one instruction per handshake and issues its code for N beats.
// Optional macro ALU_CTRL_ILLEGAL_EN adds illegal_o and retires unknown ALUOp=10 functs without a beat.
module alu_ctrl_seq #(
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned ITER_W     = 8,
    parameter int unsigned POOL_BEATS = 4,
    parameter int unsigned FC_BEATS   = 16,
    parameter int unsigned CONV_BEATS = 9,
    parameter int unsigned BN_BEATS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    input  logic [9:0]        funct_i,
    input  logic [1:0]        ALUOp_i,
    output logic              ready_o,
    input  logic              alu_ready_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ALUCtrl_o,
    output logic              alu_valid_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              first_o,
    output logic              last_o,
    output logic              busy_o,
`ifdef ALU_CTRL_ILLEGAL_EN
    output logic              illegal_o,
`endif
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CTRL_W-1:0] r_ctrl, w_ctrl_nxt;
    logic [ITER_W-1:0] r_iter, w_iter_nxt;
    logic [ITER_W-1:0] r_last, w_last_nxt;
    logic [CTRL_W-1:0] w_dec_code;
    logic [ITER_W-1:0] w_dec_last;
    logic              w_accept;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic              w_dec_illegal;
    logic              r_illegal, w_illegal_nxt;
`endif

    // Instruction decode: control code and final beat index (N-1)
    always_comb begin
        w_dec_code = CTRL_W'(4'd1);
        w_dec_last = '0;
`ifdef ALU_CTRL_ILLEGAL_EN
        w_dec_illegal = 1'b0;
`endif
        case (ALUOp_i)
            2'b01: w_dec_code = CTRL_W'(4'd2);
            2'b10: begin
                case (funct_i)
                    10'b0000000000: w_dec_code = CTRL_W'(4'd1);
                    10'b0100000000: w_dec_code = CTRL_W'(4'd2);
                    10'b0000001000: w_dec_code = CTRL_W'(4'd6);
                    10'b0000000110: w_dec_code = CTRL_W'(4'd4);
                    10'b0000000111: w_dec_code = CTRL_W'(4'd3);
                    10'b1000000111: w_dec_code = CTRL_W'(4'd7);
                    10'b1100000111: begin
                        w_dec_code = CTRL_W'(4'd8);
                        w_dec_last = ITER_W'(POOL_BEATS - 1);
                    end
                    10'b1110000111: begin
                        w_dec_code = CTRL_W'(4'd9);
                        w_dec_last = ITER_W'(FC_BEATS - 1);
                    end
                    10'b1111000111: begin
                        w_dec_code = CTRL_W'(4'd10);
                        w_dec_last = ITER_W'(CONV_BEATS - 1);
                    end
                    10'b1010000111: begin
                        w_dec_code = CTRL_W'(4'd11);
                        w_dec_last = ITER_W'(BN_BEATS - 1);
                    end
`ifdef ALU_CTRL_ILLEGAL_EN
                    default: w_dec_illegal = 1'b1;
`else
                    default: w_dec_code = CTRL_W'(4'd1);
`endif
                endcase
            end
            default: w_dec_code = CTRL_W'(4'd1);
        endcase
    end

    assign ready_o  = rst_n_i && (r_state == S_IDLE);
    assign w_accept = valid_i && ready_o && !flush_i;

    // Next-state and datapath update; flush outranks accept and the final beat
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = r_ctrl;
        w_iter_nxt  = r_iter;
        w_last_nxt  = r_last;
`ifdef ALU_CTRL_ILLEGAL_EN
        w_illegal_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef ALU_CTRL_ILLEGAL_EN
                    if (w_dec_illegal) begin
                        w_state_nxt   = S_DONE;
                        w_illegal_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_ctrl_nxt  = w_dec_code;
                        w_last_nxt  = w_dec_last;
                        w_iter_nxt  = '0;
                    end
`else
                    w_state_nxt = S_RUN;
                    w_ctrl_nxt  = w_dec_code;
                    w_last_nxt  = w_dec_last;
                    w_iter_nxt  = '0;
`endif
                end
            end
            S_RUN: begin
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (alu_ready_i) begin
                    if (r_iter == r_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_iter_nxt = r_iter + ITER_W'(1);
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_ctrl  <= CTRL_W'(4'd1);
            r_iter  <= '0;
            r_last  <= '0;
`ifdef ALU_CTRL_ILLEGAL_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_iter  <= w_iter_nxt;
            r_last  <= w_last_nxt;
`ifdef ALU_CTRL_ILLEGAL_EN
            r_illegal <= w_illegal_nxt;
`endif
        end
    end

    assign ALUCtrl_o   = r_ctrl;
    assign alu_valid_o = (r_state == S_RUN);
    assign iter_o      = r_iter;
    assign first_o     = alu_valid_o && (r_iter == '0);
    assign last_o      = alu_valid_o && (r_iter == r_last);
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
`ifdef ALU_CTRL_ILLEGAL_EN
    assign illegal_o   = r_illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: driver queues expected beats/done pulses, a monitor checks them.
module tb_alu_ctrl_seq;

    localparam int unsigned CTRL_W = 4;
    localparam int unsigned ITER_W = 8;
    localparam int POOL_B = 4;
    localparam int FC_B   = 16;
    localparam int CONV_B = 9;
    localparam int BN_B   = 2;

    localparam logic [9:0] KEYS [10] = '{10'b0000000000, 10'b0100000000, 10'b0000001000,
        10'b0000000110, 10'b0000000111, 10'b1000000111, 10'b1100000111, 10'b1110000111,
        10'b1111000111, 10'b1010000111};
    localparam int CODES [10] = '{1, 2, 6, 4, 3, 7, 8, 9, 10, 11};
    localparam int NBEATS [10] = '{1, 1, 1, 1, 1, 1, POOL_B, FC_B, CONV_B, BN_B};

    logic              clk = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              valid_i = 1'b0;
    logic [9:0]        funct_i = '0;
    logic [1:0]        ALUOp_i = '0;
    logic              alu_ready_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              ready_o, alu_valid_o, first_o, last_o, busy_o, done_o;
    logic [CTRL_W-1:0] ALUCtrl_o;
    logic [ITER_W-1:0] iter_o;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic              illegal_o;
`endif

    alu_ctrl_seq #(
        .CTRL_W(CTRL_W), .ITER_W(ITER_W), .POOL_BEATS(POOL_B),
        .FC_BEATS(FC_B), .CONV_BEATS(CONV_B), .BN_BEATS(BN_B)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .valid_i(valid_i), .funct_i(funct_i),
        .ALUOp_i(ALUOp_i), .ready_o(ready_o), .alu_ready_i(alu_ready_i),
        .flush_i(flush_i), .ALUCtrl_o(ALUCtrl_o), .alu_valid_o(alu_valid_o),
        .iter_o(iter_o), .first_o(first_o), .last_o(last_o), .busy_o(busy_o),
`ifdef ALU_CTRL_ILLEGAL_EN
        .illegal_o(illegal_o),
`endif
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct { int code; int iter; bit first; bit last; } beat_t;
    typedef struct { bit ill; int cycles; } done_t;
    beat_t q_beat [$];
    done_t q_done [$];
    int n_checks = 0;
    int n_pass   = 0;
    int run_cyc  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference decode straight from the instruction table
    function automatic void ref_decode(input logic [1:0] op, input logic [9:0] f,
                                       output int code, output int n, output bit ill);
        bit found = 1'b0;
        code = 1; n = 1; ill = 1'b0;
        if (op == 2'b01) code = 2;
        else if (op == 2'b10) begin
            for (int i = 0; i < 10; i++) begin
                if (f == KEYS[i]) begin
                    code = CODES[i]; n = NBEATS[i]; found = 1'b1;
                end
            end
`ifdef ALU_CTRL_ILLEGAL_EN
            if (!found) ill = 1'b1;
`endif
        end
    endfunction

    // mode: 0 random alu_ready, 1 always ready, 2 stall once at beats 3 and 6
    task automatic issue(input logic [1:0] op, input logic [9:0] f, input int mode,
                         input int abort_at, input bit abort_rst, input bit lat);
        int code, n, cyc, consumed, w;
        bit ill, ar, ab, s3, s6, aborted;
        ref_decode(op, f, code, n, ill);
        w = 0;
        while (!ready_o && w < 50) begin tick(); w++; end
        check("ready_wait", int'(ready_o), 1);
        valid_i = 1'b1; ALUOp_i = op; funct_i = f;
        tick();
        valid_i = 1'b0; ALUOp_i = 2'($urandom); funct_i = 10'($urandom);
        if (lat) check("lat_beat_valid", int'(alu_valid_o), 1);
        aborted = 1'b0;
        if (ill) begin
            q_done.push_back('{1'b1, 0});
        end else begin
            cyc = 0; consumed = 0; s3 = 1'b0; s6 = 1'b0;
            while (consumed < n && !aborted) begin
                if (mode == 0) ar = ($urandom % 4) != 0;
                else if (mode == 2 && consumed == 3 && !s3) begin ar = 1'b0; s3 = 1'b1; end
                else if (mode == 2 && consumed == 6 && !s6) begin ar = 1'b0; s6 = 1'b1; end
                else ar = 1'b1;
                ab = (consumed == abort_at);
                if (ab && abort_rst) begin
                    alu_ready_i = 1'b0;
                    rst_n_i = 1'b0;
                    tick();
                    check("rst_mid_ready", int'(ready_o), 0);
                    check("rst_mid_valid", int'(alu_valid_o), 0);
                    tick();
                    rst_n_i = 1'b1;
                    aborted = 1'b1;
                end else if (ab) begin
                    check("flush_iter", int'(iter_o), abort_at);
                    alu_ready_i = ar; flush_i = 1'b1;
                    tick();
                    flush_i = 1'b0; alu_ready_i = 1'b0;
                    check("flush_valid", int'(alu_valid_o), 0);
                    check("flush_done", int'(done_o), 0);
                    check("flush_ready", int'(ready_o), 1);
                    aborted = 1'b1;
                end else begin
                    alu_ready_i = ar;
                    if (ar) q_beat.push_back('{code, consumed, consumed == 0, consumed == n - 1});
                    cyc++;
                    tick();
                    if (ar) consumed++;
                end
            end
            alu_ready_i = 1'b0;
            if (!aborted) q_done.push_back('{1'b0, cyc});
        end
        if (lat && !aborted) begin
            check("lat_done", int'(done_o), 1);
            tick();
            check("lat_ready", int'(ready_o), 1);
        end
    endtask

    // Monitor: compare every consumed beat and every done pulse against the scoreboard
    always @(negedge clk) begin
        beat_t b;
        done_t d;
        if (ready_o) run_cyc = 0;
        if (alu_valid_o) run_cyc++;
        if (alu_valid_o && alu_ready_i && !flush_i && rst_n_i) begin
            check("beat_expected", int'(q_beat.size() != 0), 1);
            if (q_beat.size() != 0) begin
                b = q_beat.pop_front();
                check("beat_ctrl", int'(ALUCtrl_o), b.code);
                check("beat_iter", int'(iter_o), b.iter);
                check("beat_first", int'(first_o), int'(b.first));
                check("beat_last", int'(last_o), int'(b.last));
            end
        end
        if (done_o) begin
            check("done_expected", int'(q_done.size() != 0), 1);
            if (q_done.size() != 0) begin
                d = q_done.pop_front();
                check("done_run_cycles", run_cyc, d.cycles);
                check("done_no_valid", int'(alu_valid_o), 0);
`ifdef ALU_CTRL_ILLEGAL_EN
                check("done_illegal", int'(illegal_o), int'(d.ill));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0] op;
        logic [9:0] f;
        int ab;
        // Reset with a pending instruction
        rst_n_i = 1'b0; valid_i = 1'b1; ALUOp_i = 2'b10; funct_i = 10'b1110000111;
        tick(); tick();
        check("rst_ctrl", int'(ALUCtrl_o), 1);
        check("rst_valid", int'(alu_valid_o), 0);
        check("rst_ready", int'(ready_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_iter", int'(iter_o), 0);
        valid_i = 1'b0;
        rst_n_i = 1'b1;
        #1;
        check("rst_release_ready", int'(ready_o), 1);
        // Flush in IDLE blocks acceptance
        valid_i = 1'b1; flush_i = 1'b1; ALUOp_i = 2'b10; funct_i = 10'b0100000000;
        tick();
        valid_i = 1'b0; flush_i = 1'b0;
        check("idle_flush_busy", int'(busy_o), 0);
        check("idle_flush_ready", int'(ready_o), 1);
        // Directed cases
        issue(2'b10, 10'b0100000000, 1, -1, 1'b0, 1'b1);
        issue(2'b10, 10'b1111000111, 2, -1, 1'b0, 1'b0);
        issue(2'b10, 10'b1110000111, 1, 5, 1'b0, 1'b0);
        issue(2'b00, 10'b0000000000, 1, -1, 1'b0, 1'b1);
        issue(2'b01, 10'b1111000111, 1, -1, 1'b0, 1'b1);
        issue(2'b11, 10'b0100000000, 1, -1, 1'b0, 1'b1);
        issue(2'b10, 10'b0000000001, 1, -1, 1'b0, 1'b0);
        issue(2'b10, 10'b1110000111, 0, 4, 1'b1, 1'b0);
        issue(2'b10, 10'b1100000111, 0, -1, 1'b0, 1'b0);
        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            op = 2'($urandom);
            if (($urandom % 3) != 0) f = KEYS[$urandom % 10];
            else f = 10'($urandom);
            ab = (($urandom % 6) == 0) ? int'($urandom % 16) : -1;
            valid_i = 1'b0;
            issue(op, f, 0, ab, 1'b0, 1'b0);
        end
        for (int k = 0; k < 5; k++) tick();
        check("end_beats_drained", q_beat.size(), 0);
        check("end_dones_drained", q_done.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
